// File: rtl/uart_temp_rx.sv
// +--------------------------------------------------------------------------------+
// | uart_temp_rx : receiver for the sensor UART frame                               |
// |   frame = start, 32-bit count, 16'h0D0A trailer, stop; all fields LSB first     |
// | Optional watchdog: define UART_TEMP_RX_TIMEOUT_EN        Revision: 1.0         |
// +--------------------------------------------------------------------------------+
`default_nettype none

module uart_temp_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx_i,
  output logic [31:0] count_o,
  output logic        count_valid_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [8:0]  C_BIT_LAST   = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0]  C_HALF_LAST  = 9'(CLKS_PER_BIT / 2 - 1);
  localparam logic [5:0]  C_DATA_LAST  = 6'd47;
  localparam logic [15:0] C_CRLF       = 16'h0D0A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic        rx_prev_q;
  logic [8:0]  timer_q;
  logic [5:0]  bitcnt_q;
  logic [47:0] shift_q;
  logic [31:0] count_q;
  logic        count_valid_q;
  logic        frame_err_q;
  logic        busy_q;
  logic        rx_fall;

  assign rx_fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      timer_q       <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rx_meta_q     <= uart_rx_i;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      count_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_fall) begin
            state_q <= S_START;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (timer_q == C_HALF_LAST) begin
            timer_q  <= '0;
            bitcnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 9'd1;
          end
        end
        S_DATA: begin
          // Shift in from the top so the first bit on the line lands in bit 0.
          if (timer_q == C_BIT_LAST) begin
            timer_q  <= '0;
            shift_q  <= {rx_s_q, shift_q[47:1]};
            bitcnt_q <= bitcnt_q + 6'd1;
            if (bitcnt_q == C_DATA_LAST) begin
              state_q <= S_STOP;
            end
          end else begin
            timer_q <= timer_q + 9'd1;
          end
        end
        S_STOP: begin
          if (timer_q == C_BIT_LAST) begin
            timer_q <= '0;
            if (rx_s_q && (shift_q[47:32] == C_CRLF)) begin
              count_q       <= shift_q[31:0];
              count_valid_q <= 1'b1;
              state_q       <= S_IDLE;
              busy_q        <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              if (rx_s_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_BREAK;
              end
            end
          end else begin
            timer_q <= timer_q + 9'd1;
          end
        end
        S_BREAK: begin
          // Leave only once the line is high so a held-low line cannot re-trigger.
          if (rx_s_q) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count_o       = count_q;
  assign count_valid_o = count_valid_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = busy_q;

`ifdef UART_TEMP_RX_TIMEOUT_EN
  localparam logic [31:0] C_WD_LAST = 32'(TIMEOUT_CLKS - 1);

  logic [31:0] wd_q;
  logic        timeout_q;

  // Only a good frame feeds the watchdog; framing errors do not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (count_valid_q) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (wd_q == C_WD_LAST) begin
      timeout_q <= 1'b1;
    end else begin
      wd_q <= wd_q + 32'd1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_temp_rx.sv
// +--------------------------------------------------------------------------------+
// | tb_uart_temp_rx : randomized frame bench for uart_temp_rx     Revision: 1.0     |
// +--------------------------------------------------------------------------------+
`default_nettype none

module tb_uart_temp_rx;

  localparam int BAUD     = 115200;
  localparam int CPB      = 21;
  localparam int CLK_FREQ = CPB * BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = HALF + 49 * CPB;
  localparam int TO_CLKS  = 100000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] count_o;
  logic        count_valid_o;
  logic        frame_err_o;
  logic        busy_o;
  logic        timeout_o;

  uart_temp_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD),
    .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rx_i    (rx),
    .count_o      (count_o),
    .count_valid_o(count_valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_err = 0, n_both = 0, n_busy = 0, last_valid_cyc = 0;
  always @(negedge clk) begin
    if (count_valid_o) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err_o) n_err <= n_err + 1;
    if (count_valid_o && frame_err_o) n_both <= n_both + 1;
    if (busy_o) n_busy <= n_busy + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: the frame is judged only on its trailer and stop bit.
  logic [31:0] exp_count = '0;
  int          exp_valid = 0, exp_err = 0;
  int          start_cyc = 0;

  task automatic model_frame(input logic [31:0] d, input logic [15:0] tr, input bit stp);
    if (tr == 16'h0D0A && stp) begin
      exp_count = d;
      exp_valid++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] d, input logic [15:0] tr, input bit stp,
                           input int brk, input int gap);
    logic [49:0] bits;
    model_frame(d, tr, stp);
    bits = {stp, tr, d, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < 50; i++) drive_bit(bits[i]);
    if (!stp) begin
      repeat (brk) @(negedge clk);
      if (brk >= CPB) check_eq("break_busy", 64'(busy_o), 64'd1);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    check_eq("count", 64'(count_o), 64'(exp_count));
    check_eq("valid_cnt", 64'(n_valid), 64'(exp_valid));
    check_eq("err_cnt", 64'(n_err), 64'(exp_err));
    check_eq("busy_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] tr;
    int          kind;
    int          busy_before;

    // Reset and idle line
    repeat (5) @(negedge clk);
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("idle_count", 64'(count_o), 64'd0);
    check_eq("idle_valid", 64'(n_valid), 64'd0);
    check_eq("idle_err", 64'(n_err), 64'd0);
    check_eq("idle_busy", 64'(busy_o), 64'd0);
    check_eq("idle_timeout", 64'(timeout_o), 64'd0);

    // Good frame with latency check
    run_frame(32'hDEADBEEF, 16'h0D0A, 1'b1, 0, 2 * CPB);
    check_eq("latency", 64'(last_valid_cyc - start_cyc), 64'(LAT + 3));

    // Short low glitch is a false start
    busy_before = n_busy;
    @(negedge clk);
    rx = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("glitch_busy_seen", 64'(n_busy > busy_before), 64'd1);
    check_eq("glitch_valid", 64'(n_valid), 64'(exp_valid));
    check_eq("glitch_err", 64'(n_err), 64'(exp_err));
    check_eq("glitch_busy_idle", 64'(busy_o), 64'd0);

    // Bad trailer after a good frame, then bad stop with a long break
    run_frame(32'h00001234, 16'h0D0A, 1'b1, 0, CPB);
    run_frame(32'h0BADF00D, 16'h0D0B, 1'b1, 0, CPB);
    run_frame(32'h55AA55AA, 16'h0D0A, 1'b0, 5000, CPB);
    run_frame(32'h00000001, 16'h0D0A, 1'b1, 0, 0);
    run_frame(32'h76543210, 16'h0D0A, 1'b1, 0, CPB);

    // Randomized frames, including back-to-back ones
    for (int f = 0; f < 16; f++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom;
      tr   = (kind == 2) ? (16'h0D0A ^ (16'h1 << $urandom_range(0, 15))) : 16'h0D0A;
      run_frame(d, tr, kind != 3, $urandom_range(0, 3 * CPB), $urandom_range(0, 2) * 10);
    end

    // Reset in the middle of data bit 20
    @(negedge clk);
    d = 32'hCAFEF00D;
    drive_bit(1'b0);
    for (int i = 0; i < 20; i++) drive_bit(d[i]);
    rx = d[20];
    repeat (HALF) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_count", 64'(count_o), 64'd0);
    check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
    check_eq("mid_rst_valid", 64'(count_valid_o), 64'd0);
    check_eq("mid_rst_err", 64'(frame_err_o), 64'd0);
    check_eq("mid_rst_timeout", 64'(timeout_o), 64'd0);
    rx = 1'b1;
    reset_n = 1'b1;
    exp_count = '0;
    repeat (2 * CPB) @(negedge clk);
    run_frame(32'hCAFEF00D, 16'h0D0A, 1'b1, 0, CPB);

`ifdef UART_TEMP_RX_TIMEOUT_EN
    repeat (TO_CLKS + 10) @(negedge clk);
    check_eq("timeout_set", 64'(timeout_o), 64'd1);
    run_frame(32'h13572468, 16'h0D0A, 1'b1, 0, CPB);
    check_eq("timeout_clr", 64'(timeout_o), 64'd0);
`else
    check_eq("timeout_tied", 64'(timeout_o), 64'd0);
`endif

    check_eq("both_high", 64'(n_both), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
